// File: rtl/telem_frame_sched.sv
// Telemetry frame scheduler: round-robin picks one requester, captures its
// 32-bit word and streams a 7-byte framed packet to a byte-serial UART.
//
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   req, payload   per-requester request level and 32-bit word
//   ack            one-cycle capture pulse to the granted requester
//   tx_data        byte to the transmitter, held from strobe to completion
//   tx_send        one-cycle send strobe
//   tx_busy        transmitter busy handshake
//   sched_busy     high while a frame is in flight
//   cur_src        index of the granted requester
//   done, err      frame complete / frame aborted on handshake timeout
module telem_frame_sched #(
    parameter int NUM_REQ     = 4,
    parameter int WAIT_HI_MAX = 15
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NUM_REQ-1:0]     req,
    input  logic [32*NUM_REQ-1:0]  payload,
    output logic [NUM_REQ-1:0]     ack,
    output logic [7:0]             tx_data,
    output logic                   tx_send,
    input  logic                   tx_busy,
    output logic                   sched_busy,
    output logic [2:0]             cur_src,
    output logic                   done,
    output logic                   err
);

    localparam int TW = $clog2(WAIT_HI_MAX + 1);

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        WAIT_HI,
        WAIT_LO
    } state_t;

    state_t         state;
    logic [2:0]     last_grant;
    logic [2:0]     idx;
    logic [TW-1:0]  tcnt;
    logic [31:0]    cap;

    logic [2:0]     win;
    logic           win_vld;
    logic [31:0]    psel;
    logic [7:0]     src_byte;
    logic [7:0]     csum;
    logic [7:0]     cur_byte;
    int             rr_j;

    // Round-robin search from last_grant+1. The loop runs from the farthest
    // offset down so the nearest requesting index is written last and wins.
    always_comb begin
        win     = '0;
        win_vld = 1'b0;
        rr_j    = 0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            rr_j = (int'(last_grant) + k) % NUM_REQ;
            if ((req & (NUM_REQ'(1) << rr_j)) != '0) begin
                win     = 3'(rr_j);
                win_vld = 1'b1;
            end
        end
    end

    assign psel     = 32'(payload >> (32 * int'(win)));
    assign src_byte = {5'b0, cur_src};
    assign csum     = src_byte ^ cap[31:24] ^ cap[23:16]
                    ^ cap[15:8] ^ cap[7:0];

    always_comb begin
        cur_byte = 8'h00;
        case (idx)
            3'd0:    cur_byte = 8'hA5;
            3'd1:    cur_byte = src_byte;
            3'd2:    cur_byte = cap[31:24];
            3'd3:    cur_byte = cap[23:16];
            3'd4:    cur_byte = cap[15:8];
            3'd5:    cur_byte = cap[7:0];
            3'd6:    cur_byte = csum;
            default: cur_byte = 8'h00;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            last_grant <= 3'(NUM_REQ - 1);
            idx        <= '0;
            tcnt       <= '0;
            cap        <= '0;
            ack        <= '0;
            tx_data    <= 8'h00;
            tx_send    <= 1'b0;
            sched_busy <= 1'b0;
            cur_src    <= '0;
            done       <= 1'b0;
            err        <= 1'b0;
        end else begin
            ack     <= '0;
            tx_send <= 1'b0;
            done    <= 1'b0;
            err     <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (win_vld) begin
                        cap        <= psel;
                        last_grant <= win;
                        cur_src    <= win;
                        ack        <= NUM_REQ'(1) << win;
                        idx        <= '0;
                        sched_busy <= 1'b1;
                        state      <= SEND;
                    end
                end
                SEND: begin
                    if (!tx_busy) begin
                        tx_data <= cur_byte;
                        tx_send <= 1'b1;
                        tcnt    <= '0;
                        state   <= WAIT_HI;
                    end
                end
                WAIT_HI: begin
                    if (tx_busy) begin
                        state <= WAIT_LO;
                    end else if (tcnt == TW'(WAIT_HI_MAX - 1)) begin
                        // Transmitter never acknowledged: drop the frame.
                        err        <= 1'b1;
                        sched_busy <= 1'b0;
                        state      <= IDLE;
                    end else begin
                        tcnt <= tcnt + 1'b1;
                    end
                end
                WAIT_LO: begin
                    if (!tx_busy) begin
                        if (idx == 3'd6) begin
                            done       <= 1'b1;
                            sched_busy <= 1'b0;
                            state      <= IDLE;
                        end else begin
                            idx   <= idx + 3'd1;
                            state <= SEND;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/telem_frame_sched.md
TELEM_FRAME_SCHED -- requirements
Module: telem_frame_sched

Interface
REQ-001 Parameter NUM_REQ, default 4, number of telemetry requesters (2..8).
REQ-002 Parameter WAIT_HI_MAX, default 15, maximum cycles to wait for tx_busy to rise after tx_send.
REQ-003 clk  input  1  clock; all logic on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 req  input  NUM_REQ  per-requester frame request level, held until matching ack.
REQ-006 payload  input  32*NUM_REQ  per-requester 32-bit word; requester i uses bits [32*i+31:32*i].
REQ-007 ack  output  NUM_REQ  one-cycle pulse: payload of requester i captured, req may drop.
REQ-008 tx_data  output  8  byte to the byte-serial UART transmitter.
REQ-009 tx_send  output  1  one-cycle send strobe to the transmitter.
REQ-010 tx_busy  input  1  transmitter busy, rises one or more cycles after tx_send.
REQ-011 sched_busy  output  1  high from capture until the frame ends.
REQ-012 cur_src  output  3  index of the requester whose frame is in flight.
REQ-013 done  output  1  one-cycle pulse when the last frame byte completes.
REQ-014 err  output  1  one-cycle pulse when a frame is aborted on timeout.

Function
REQ-015 Frame SHALL be 7 bytes, in order: 0xA5, {5'b0,cur_src}, payload[31:24], [23:16], [15:8], [7:0], checksum.
REQ-016 Checksum SHALL be XOR of bytes 1..5 (source byte and four payload bytes).
REQ-017 States SHALL be IDLE, SEND, WAIT_HI, WAIT_LO.
REQ-018 Arbitration: round-robin; search starts at (last_grant+1) mod NUM_REQ; last_grant resets to NUM_REQ-1 so requester 0 wins first.
REQ-019 IDLE with any req high: on that edge capture winner payload, update last_grant/cur_src, set ack[winner]=1 for exactly one cycle, byte index=0, go SEND.
REQ-020 req sampled only in IDLE; requests arriving mid-frame wait; no requester granted twice while another is pending (fairness).
REQ-021 SEND: when tx_busy=0, drive tx_data=byte[index], tx_send=1 for one cycle, go WAIT_HI; when tx_busy=1, stay in SEND with tx_send=0.
REQ-022 WAIT_HI: tx_busy=1 -> WAIT_LO; after WAIT_HI_MAX cycles without tx_busy -> err pulse, IDLE, frame dropped.
REQ-023 WAIT_LO: tx_busy=0 and index<6 -> index+1, SEND; tx_busy=0 and index=6 -> done pulse, IDLE.
REQ-024 tx_data SHALL remain stable from the tx_send cycle until the state leaves WAIT_LO.
REQ-025 tx_send SHALL never assert outside SEND and never on two consecutive cycles.
REQ-026 sched_busy=1 in every state except IDLE; cur_src holds last granted index in IDLE.
REQ-027 done and err SHALL be mutually exclusive; a new grant may occur the cycle after done or err (back-to-back frames).
REQ-028 Captured payload SHALL be immune to later changes on payload inputs.

Reset
REQ-029 rst_n low SHALL immediately force: state IDLE, tx_send=0, tx_data=0x00, ack=0, done=0, err=0, sched_busy=0, cur_src=0, last_grant=NUM_REQ-1, index=0, timeout counter=0.
REQ-030 Reset mid-frame SHALL abandon the frame without done/err; first post-reset grant follows REQ-018.

Verification
REQ-031 req=0001, payload0=0x11223344, transmitter model busy 1 cycle after send for 10 cycles -> ack[0] pulse; bytes A5 00 11 22 33 44 44; one done.
REQ-032 req=1111 held, re-raised after each ack -> grant order 0,1,2,3,0; each frame byte1 equals source index.
REQ-033 tx_busy never rises after tx_send -> err after 15 WAIT_HI cycles, no done, IDLE, tx_send low.
REQ-034 payload0 changed to 0xFFFFFFFF one cycle after ack[0] -> transmitted bytes still 11 22 33 44, checksum 0x44.
REQ-035 rst_n asserted during byte 3 -> all outputs at reset values same cycle; after release req=0100 -> requester 2 frame correct from 0xA5.
REQ-036 tx_busy held high at SEND entry for 5 cycles -> tx_send withheld until busy low, then single strobe.
